// File: rtl/router_mux_rr_if.sv
// Input-port and output-port bundle for the round-robin output-port multiplexer.
interface router_mux_rr_if #(
    parameter int unsigned NUMPORTS = 4,
    parameter int unsigned DWIDTH   = 64,
    parameter int unsigned DESTW    = 8
);
    localparam int unsigned SRCW = $clog2(NUMPORTS);

    logic [NUMPORTS-1:0][DWIDTH-1:0] D;
    logic [NUMPORTS-1:0][DESTW-1:0]  DEST;
    logic [NUMPORTS-1:0]             DEST_VALID;
    logic [NUMPORTS-1:0]             D_HDR_VALID;
    logic [NUMPORTS-1:0]             D_PLD_VALID;
    logic [NUMPORTS-1:0]             D_SOF;
    logic [NUMPORTS-1:0]             D_EOF;
    logic [NUMPORTS-1:0]             D_BP;
    logic [NUMPORTS-1:0]             COLLISION;
    logic                            Q_BP;
    logic [DWIDTH-1:0]               Q;
    logic                            Q_HDR_VALID;
    logic                            Q_PLD_VALID;
    logic                            Q_SOF;
    logic                            Q_EOF;
    logic [SRCW-1:0]                 Q_SRC;
    logic                            Q_ABORT;

    modport master (
        output D, DEST, DEST_VALID, D_HDR_VALID, D_PLD_VALID, D_SOF, D_EOF, Q_BP,
        input  D_BP, COLLISION, Q, Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF, Q_SRC, Q_ABORT
    );

    modport slave (
        input  D, DEST, DEST_VALID, D_HDR_VALID, D_PLD_VALID, D_SOF, D_EOF, Q_BP,
        output D_BP, COLLISION, Q, Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF, Q_SRC, Q_ABORT
    );
endinterface

// File: rtl/router_mux_rr.sv
// Output-port multiplexer: destination-matched SOF requests granted round-robin,
// grant locked SOF..EOF, owner beats forwarded through one registered stage.
module router_mux_rr #(
    parameter int unsigned NUMPORTS = 4,
    parameter int unsigned DWIDTH   = 64,
    parameter int unsigned DESTW    = 8,
    parameter int unsigned PORT_NO  = 1
) (
    input  logic           CLK,
    input  logic           RST,
    router_mux_rr_if.slave bus
);
    localparam int unsigned SRCW = $clog2(NUMPORTS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [SRCW-1:0]     r_ptr;
    logic [SRCW-1:0]     r_owner;
    logic [DWIDTH-1:0]   r_q;
    logic                r_q_hdr;
    logic                r_q_pld;
    logic                r_q_sof;
    logic                r_q_eof;
    logic [SRCW-1:0]     r_q_src;
    logic                r_q_abort;

    logic [NUMPORTS-1:0] w_req;
    logic [NUMPORTS-1:0] w_d_bp;
    logic [SRCW-1:0]     w_cand;
    logic [SRCW-1:0]     w_gnt_idx;
    logic                w_gnt_vld;
    logic                w_grant;
    logic                w_own_dv;
    logic                w_own_hdr;
    logic                w_own_pld;
    logic                w_own_eof;
    logic                w_own_vld;
    logic                w_eof_acc;
    logic                w_abort;
    logic [SRCW-1:0]     w_ptr_nxt;

    always_comb begin
        for (int unsigned i = 0; i < NUMPORTS; i++) begin
            w_req[i] = bus.DEST_VALID[i] & (bus.DEST[i] == DESTW'(PORT_NO)) & bus.D_SOF[i];
        end
    end

    // First requester at or after r_ptr, wrapping modulo NUMPORTS.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int unsigned k = 0; k < NUMPORTS; k++) begin
            w_cand = SRCW'((32'(r_ptr) + k) % NUMPORTS);
            if (!w_gnt_vld && w_req[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_own_dv  = bus.DEST_VALID[r_owner];
    assign w_own_hdr = bus.D_HDR_VALID[r_owner];
    assign w_own_pld = bus.D_PLD_VALID[r_owner];
    assign w_own_eof = bus.D_EOF[r_owner];
    assign w_own_vld = w_own_hdr | w_own_pld;

    // Every transition is gated by downstream acceptance so a pending SOF/EOF is never overwritten.
    assign w_grant   = (r_state == ST_IDLE) & w_gnt_vld & ~bus.Q_BP;
    assign w_eof_acc = (r_state == ST_BUSY) & ~bus.Q_BP & w_own_dv & w_own_eof & w_own_vld;
    assign w_abort   = (r_state == ST_BUSY) & ~bus.Q_BP & ~w_own_dv;
    assign w_ptr_nxt = (r_owner == SRCW'(NUMPORTS - 1)) ? '0 : r_owner + SRCW'(1);

    always_comb begin
        w_d_bp = '0;
        for (int unsigned i = 0; i < NUMPORTS; i++) begin
            if ((r_state == ST_BUSY) && (SRCW'(i) == r_owner)) begin
                w_d_bp[i] = bus.Q_BP;
            end else if (w_req[i] && !(w_grant && (SRCW'(i) == w_gnt_idx))) begin
                w_d_bp[i] = 1'b1;
            end
        end
    end

    assign bus.D_BP      = w_d_bp;
    assign bus.COLLISION = w_d_bp & w_req;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_q       <= '0;
            r_q_hdr   <= 1'b0;
            r_q_pld   <= 1'b0;
            r_q_sof   <= 1'b0;
            r_q_eof   <= 1'b0;
            r_q_src   <= '0;
            r_q_abort <= 1'b0;
        end else if (!bus.Q_BP) begin
            case (r_state)
                ST_IDLE: begin
                    r_q_hdr   <= 1'b0;
                    r_q_pld   <= 1'b0;
                    r_q_eof   <= 1'b0;
                    r_q_abort <= 1'b0;
                    r_q_sof   <= w_gnt_vld;
                    if (w_gnt_vld) begin
                        r_owner <= w_gnt_idx;
                        r_q_src <= w_gnt_idx;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_q_sof <= 1'b0;
                    if (w_abort) begin
                        r_q_hdr   <= 1'b0;
                        r_q_pld   <= 1'b0;
                        r_q_eof   <= 1'b1;
                        r_q_abort <= 1'b1;
                        r_ptr     <= w_ptr_nxt;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_q       <= bus.D[r_owner];
                        r_q_hdr   <= w_own_hdr;
                        r_q_pld   <= w_own_pld;
                        r_q_eof   <= w_own_eof & w_own_vld;
                        r_q_abort <= 1'b0;
                        if (w_eof_acc) begin
                            r_ptr   <= w_ptr_nxt;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Q           = r_q;
    assign bus.Q_HDR_VALID = r_q_hdr;
    assign bus.Q_PLD_VALID = r_q_pld;
    assign bus.Q_SOF       = r_q_sof;
    assign bus.Q_EOF       = r_q_eof;
    assign bus.Q_SRC       = r_q_src;
    assign bus.Q_ABORT     = r_q_abort;
endmodule
